ex_muldiv_unit: RTL and testbench
=================================

# ex_muldiv_unit

Iterative unsigned 64-bit multiply/divide unit in the EX stage. It consumes operands and the M-extension opcode as they leave the ID/EX pipeline register. While an operation is in flight, it asserts `stall` back to the hazard logic so that ID/EX and the earlier stages hold. It returns a registered 64-bit result with a one-cycle `done` pulse. Multiply is radix-2 shift-add; divide is radix-2 restoring. Both take XLEN iterations.

## Interface
- `XLEN`, default 64: operand and result width.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request; the op in EX is a mul/div instruction.
- `op`  in  2: operation select.
  - 00 MUL: low XLEN bits of product.
  - 01 MULHU: high XLEN bits of product.
  - 10 DIVU: quotient.
  - 11 REMU: remainder.
- `rs1`  in  XLEN: multiplicand or dividend (EX_ReadData1).
- `rs2`  in  XLEN: multiplier or divisor (EX_ReadData2).
- `flush`  in  1: abort, e.g. branch mispredict.
- `busy`  out  1: state is RUN.
- `stall`  out  1: combinational; hold the ID/EX register and earlier stages.
- `done`  out  1: registered; one-cycle pulse, `result` valid.
- `result`  out  XLEN: registered result; holds until next completion.

## Operation
- States: IDLE, RUN, DONE.
- Accept: `start`=1 in IDLE or DONE, with `flush`=0, at a rising edge.
  - Latch `rs1`, `rs2` and `op`.
  - Clear the accumulator / partial remainder.
  - Set iteration counter to XLEN-1.
  - Go to RUN.
- Divide by zero: if `op[1]`=1 and `rs2`=0 at accept, go directly to DONE.
  - DIVU: `result` = all ones.
  - REMU: `result` = `rs1`.
- RUN, multiply: 2·XLEN-bit product register {hi, lo}, with lo preloaded with `rs1`.
  - Each cycle: if lo[0], hi += `rs2` (XLEN+1-bit sum).
  - Then shift {carry, hi, lo} right by 1.
- RUN, divide: partial remainder R (XLEN+1 bits), dividend/quotient register Q.
  - Each cycle: R = {R, Q[msb]}; Q <<= 1.
  - If R ≥ divisor: R -= divisor; Q[0] = 1.
- In RUN, the counter decrements each cycle. On the cycle where counter = 0, the last iteration executes, `result` is loaded from the op-selected field, and the state goes to DONE.
  - MUL → lo; MULHU → hi; DIVU → Q; REMU → R[XLEN-1:0].
- DONE: `done`=1 for exactly this cycle.
  - Next state is RUN if a new `start` is accepted, otherwise IDLE.
- `stall` = (RUN) OR (`start` AND (IDLE OR DONE) AND NOT `flush`). It is low in the DONE cycle unless a new op is accepted.
- `start` in RUN is ignored; the instruction is still held by `stall`.
- `flush` in any state: next state IDLE, no `done` pulse. `result` is unchanged and the in-flight op is discarded. `flush` beats a same-cycle `start`.
- `rst` wins over everything, including mid-operation. Reset values:
  - State IDLE.
  - `busy`=0, `done`=0, `stall`=0 (with `start`=0).
  - `result`=0; internal registers 0.
- Arithmetic is unsigned modulo 2^XLEN, with no overflow flag. Signed variants are out of scope.

## Timing
- Accept edge E0.
- RUN occupies the cycles after edges E0 … E(XLEN-1): 64 cycles for XLEN=64.
- `done` and a valid `result` appear after edge E(XLEN), i.e. XLEN+1 edges after accept: 65 cycles at default.
- Divide by zero: `done` appears in the cycle after E0.
- `stall` rises combinationally in the same cycle as `start` and stays high through the last RUN cycle. The dependent instruction advances at the edge ending the DONE cycle.
- Back-to-back ops: a `start` in the DONE cycle is accepted at that edge, with no IDLE gap.

## Test plan
- MUL: `rs1`=7, `rs2`=6.
  - `result`=42 with `done`, exactly 65 cycles after accept.
  - `stall` high for 64 cycles, then low in the DONE cycle.
- MULHU: `rs1`=`rs2`=0xFFFF_FFFF_FFFF_FFFF.
  - `result`=0xFFFF_FFFF_FFFF_FFFE.
  - The same operands with MUL give 1.
- DIVU and REMU: `rs1`=100, `rs2`=7.
  - DIVU gives 14; REMU gives 2.
  - `rs1`=5, `rs2`=9: DIVU gives 0, REMU gives 5.
- Divide by zero: `rs1`=0x1234, `rs2`=0.
  - DIVU gives all ones; REMU gives 0x1234.
  - `done` one cycle after accept.
- `flush` at RUN cycle 20:
  - No `done`; `busy` and `stall` are 0 next cycle.
  - `result` keeps its prior value.
  - A new MUL 3×5 then returns 15.
- Reset mid-RUN, plus back-to-back starts:
  - `rst` at RUN cycle 30 returns all outputs to 0.
  - A `start` asserted in the DONE cycle of one op runs the next op with no IDLE cycle.
  - Random operands are checked against a reference model.

Source files
------------

// File: rtl/ex_muldiv_unit_if.sv
// Handshake and data bundle between the EX-stage pipeline control and the
// iterative multiply/divide unit.
interface ex_muldiv_unit_if #(
    parameter int unsigned XLEN = 64
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, rs1, rs2, flush,
        input  busy, stall, done, result
    );

    modport slave (
        input  start, op, rs1, rs2, flush,
        output busy, stall, done, result
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative unsigned multiply (radix-2 shift-add) / divide (radix-2 restoring)
// unit; holds the pipeline via stall while an operation is in flight.
module ex_muldiv_unit #(
    parameter int unsigned XLEN = 64
) (
    input logic              clk,
    input logic              rst,
    ex_muldiv_unit_if.slave  md_io
);
    localparam int unsigned CntW = $clog2(XLEN);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] acc_q, acc_d;   // multiply: hi half; divide: partial remainder
    logic [XLEN-1:0] lo_q, lo_d;     // multiply: lo half; divide: dividend/quotient
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic            accept;
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] mul_hi, mul_lo;
    logic [XLEN:0]   div_shift;
    logic            div_ge;
    logic [XLEN-1:0] div_r, div_q;

    assign accept = md_io.start && (state_q != StRun) && !md_io.flush;

    assign mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
    assign mul_hi  = mul_sum[XLEN:1];
    assign mul_lo  = {mul_sum[0], lo_q[XLEN-1:1]};

    // The remainder after a restoring step is always below the divisor, so it fits XLEN bits.
    assign div_shift = {acc_q, lo_q[XLEN-1]};
    assign div_ge    = div_shift >= {1'b0, b_q};
    assign div_r     = div_ge ? XLEN'(div_shift - {1'b0, b_q}) : div_shift[XLEN-1:0];
    assign div_q     = {lo_q[XLEN-2:0], div_ge};

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (accept) begin
                    op_d  = md_io.op;
                    acc_d = '0;
                    lo_d  = md_io.rs1;
                    b_d   = md_io.rs2;
                    cnt_d = CntW'(XLEN - 1);
                    if (md_io.op[1] && (md_io.rs2 == '0)) begin
                        state_d  = StDone;
                        result_d = md_io.op[0] ? md_io.rs1 : '1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (op_q[1]) begin
                    acc_d = div_r;
                    lo_d  = div_q;
                end else begin
                    acc_d = mul_hi;
                    lo_d  = mul_lo;
                end
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == '0) begin
                    state_d = StDone;
                    unique case (op_q)
                        2'b00:   result_d = mul_lo;
                        2'b01:   result_d = mul_hi;
                        2'b10:   result_d = div_q;
                        default: result_d = div_r;
                    endcase
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort discards the in-flight op, including a completion on this very edge.
        if (md_io.flush) begin
            state_d  = StIdle;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign md_io.busy   = (state_q == StRun);
    assign md_io.done   = (state_q == StDone);
    assign md_io.stall  = (state_q == StRun) || accept;
    assign md_io.result = result_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed cases plus random operands
// compared against a plain-arithmetic reference model.
module tb_ex_muldiv_unit;
    logic clk;
    logic rst;
    int   passed;
    int   total;

    ex_muldiv_unit_if #(.XLEN(64)) bus ();

    ex_muldiv_unit #(.XLEN(64)) dut (
        .clk   (clk),
        .rst   (rst),
        .md_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [63:0] a,
                                              input logic [63:0] b);
        logic [127:0] p;
        p = {64'd0, a} * {64'd0, b};
        case (o)
            2'b00:   return p[63:0];
            2'b01:   return p[127:64];
            2'b10:   return (b == 64'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
            default: return (b == 64'd0) ? a : a % b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Called at a negedge; drives a request for the coming edge.
    task automatic issue(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
        bus.start = 1'b1;
        bus.op    = o;
        bus.rs1   = a;
        bus.rs2   = b;
    endtask

    // Latency counts cycles after the accept edge, sampled on negedges.
    task automatic wait_done(output logic [63:0] res, output int lat, output int stalls);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat       = 1;
        stalls    = 0;
        while (bus.done !== 1'b1 && lat < 200) begin
            if (bus.stall === 1'b1) stalls++;
            @(negedge clk);
            lat++;
        end
        if (lat >= 200) check("timeout", {63'd0, bus.done}, 64'd1);
        res = bus.result;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [63:0] a,
                          input logic [63:0] b);
        logic [63:0] res;
        int          lat;
        int          st;
        @(negedge clk);
        issue(o, a, b);
        wait_done(res, lat, st);
        check($sformatf("%s_result", tag), res, ref_model(o, a, b));
        check($sformatf("%s_latency", tag), 64'(lat), (o[1] && b == 64'd0) ? 64'd1 : 64'd65);
    endtask

    initial begin
        logic [63:0] res;
        logic [63:0] a;
        logic [63:0] b;
        logic [1:0]  o;
        int          lat;
        int          st;
        bit          saw_done;

        passed    = 0;
        total     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = 2'b00;
        bus.rs1   = '0;
        bus.rs2   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_stall", {63'd0, bus.stall}, 64'd0);
        check("rst_result", bus.result, 64'd0);
        rst = 1'b0;

        // MUL 7*6 with latency and stall profile
        @(negedge clk);
        issue(2'b00, 64'd7, 64'd6);
        #1 check("stall_comb", {63'd0, bus.stall}, 64'd1);
        wait_done(res, lat, st);
        check("mul7x6_result", res, 64'd42);
        check("mul7x6_latency", 64'(lat), 64'd65);
        check("mul7x6_stall_cycles", 64'(st), 64'd64);
        check("done_cycle_stall", {63'd0, bus.stall}, 64'd0);
        @(negedge clk);
        check("done_pulse_ends", {63'd0, bus.done}, 64'd0);

        run_op("mulhu_ones", 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        check("mulhu_ones_const", bus.result, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("mul_ones", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        check("mul_ones_const", bus.result, 64'd1);
        run_op("divu_100_7", 2'b10, 64'd100, 64'd7);
        check("divu_100_7_const", bus.result, 64'd14);
        run_op("remu_100_7", 2'b11, 64'd100, 64'd7);
        check("remu_100_7_const", bus.result, 64'd2);
        run_op("divu_5_9", 2'b10, 64'd5, 64'd9);
        check("divu_5_9_const", bus.result, 64'd0);
        run_op("remu_5_9", 2'b11, 64'd5, 64'd9);
        check("remu_5_9_const", bus.result, 64'd5);
        run_op("divu_by0", 2'b10, 64'h1234, 64'd0);
        check("divu_by0_const", bus.result, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("remu_by0", 2'b11, 64'h1234, 64'd0);
        check("remu_by0_const", bus.result, 64'h1234);

        // Flush at RUN cycle 20
        @(negedge clk);
        issue(2'b00, 64'd11, 64'd13);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy", {63'd0, bus.busy}, 64'd0);
        check("flush_stall", {63'd0, bus.stall}, 64'd0);
        check("flush_done", {63'd0, bus.done}, 64'd0);
        check("flush_result_kept", bus.result, 64'h1234);
        saw_done = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        check("flush_no_done", {63'd0, saw_done}, 64'd0);
        run_op("mul3x5", 2'b00, 64'd3, 64'd5);
        check("mul3x5_const", bus.result, 64'd15);

        // Flush beats a same-cycle start
        @(negedge clk);
        issue(2'b00, 64'd2, 64'd2);
        bus.flush = 1'b1;
        #1 check("flush_start_stall", {63'd0, bus.stall}, 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flush_start_busy", {63'd0, bus.busy}, 64'd0);

        // Reset at RUN cycle 30
        issue(2'b11, 64'd999, 64'd10);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (29) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", {63'd0, bus.busy}, 64'd0);
        check("midrst_done", {63'd0, bus.done}, 64'd0);
        check("midrst_stall", {63'd0, bus.stall}, 64'd0);
        check("midrst_result", bus.result, 64'd0);
        rst = 1'b0;

        // Random single operations
        for (int i = 0; i < 16; i++) begin
            o = 2'($urandom_range(0, 3));
            a = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       b = 64'd0;
                1:       b = 64'($urandom_range(1, 1000));
                2:       b = {32'd0, $urandom};
                default: b = {$urandom, $urandom};
            endcase
            run_op($sformatf("rand%0d", i), o, a, b);
        end

        // Back-to-back chain: each start issued in the previous DONE cycle
        @(negedge clk);
        issue(2'b00, 64'd9, 64'd9);
        wait_done(res, lat, st);
        check("b2b_first", res, 64'd81);
        for (int i = 0; i < 6; i++) begin
            o = 2'($urandom_range(0, 3));
            a = {$urandom, $urandom};
            b = (i == 2) ? 64'd0 : {32'd0, $urandom};
            issue(o, a, b);
            #1 check($sformatf("b2b%0d_stall", i), {63'd0, bus.stall}, 64'd1);
            wait_done(res, lat, st);
            check($sformatf("b2b%0d_result", i), res, ref_model(o, a, b));
            check($sformatf("b2b%0d_latency", i), 64'(lat),
                  (o[1] && b == 64'd0) ? 64'd1 : 64'd65);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
